// File: rtl/bcd_calc_seq_if.sv
// Keypad/display bus for bcd_calc_seq.
// Groups the scanner inputs (key, key_valid, in_add, in_sub, in_clr) and the
// display/status outputs (disp, neg, busy, done, mode).
//   master: keypad scanner / display side (drives keys, reads display)
//   slave : calculator controller side
interface bcd_calc_seq_if #(
  parameter int unsigned N = 2
);
  logic [3:0]     key;
  logic           key_valid;
  logic           in_add;
  logic           in_sub;
  logic           in_clr;
  logic [8*N-1:0] disp;
  logic           neg;
  logic           busy;
  logic           done;
  logic [1:0]     mode;

  modport master (
    output key, key_valid, in_add, in_sub, in_clr,
    input  disp, neg, busy, done, mode
  );

  modport slave (
    input  key, key_valid, in_add, in_sub, in_clr,
    output disp, neg, busy, done, mode
  );
endinterface

// File: rtl/bcd_calc_seq.sv
// Digit-serial BCD add/subtract keypad calculator controller.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - slave side of bcd_calc_seq_if: keypad events in, 2N-digit BCD
//          display plus neg/busy/done/mode status out (all outputs registered)
// Subtraction yields sign + magnitude: operands are swapped when A < B.
module bcd_calc_seq #(
  parameter int unsigned N = 2
) (
  input  logic           clk,
  input  logic           rst,
  bcd_calc_seq_if.slave  bus
);
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned DW = 4 * N;

  typedef enum logic [1:0] {
    StEnterA = 2'd0,
    StEnterB = 2'd1,
    StCalc   = 2'd2,
    StResult = 2'd3
  } state_e;

  state_e          r_state, w_state_nxt;
  logic [DW-1:0]   r_a, w_a_nxt, r_b, w_b_nxt;    // operands as keyed (display shadow)
  logic [DW-1:0]   r_x, w_x_nxt, r_y, w_y_nxt;    // working operands, possibly swapped
  logic [DW+3:0]   r_r, w_r_nxt;
  logic            r_c, w_c_nxt;
  logic [IW-1:0]   r_idx, w_idx_nxt;
  logic            r_op, w_op_nxt;                // 0 add, 1 sub
  logic            r_setup, w_setup_nxt;          // first CALC cycle: compare/swap
  logic            r_neg_pend, w_neg_pend_nxt;
  logic            r_neg, w_neg_nxt;
  logic [2*DW-1:0] r_disp, w_disp_nxt;
  logic            r_busy, r_done;
  logic [1:0]      r_mode;

  logic            w_key_ok;
  logic [IW+1:0]   w_lsb;
  logic [3:0]      w_xd, w_yd, w_sum_dig, w_dif_dig;
  logic [4:0]      w_sum, w_dif;
  logic            w_sum_c, w_dif_b;

  assign w_key_ok  = bus.key_valid && (bus.key <= 4'd9);
  assign w_lsb     = {r_idx, 2'b00};
  assign w_xd      = r_x[w_lsb +: 4];
  assign w_yd      = r_y[w_lsb +: 4];

  assign w_sum     = {1'b0, w_xd} + {1'b0, w_yd} + {4'b0000, r_c};
  assign w_sum_c   = (w_sum > 5'd9);
  // sum <= 19, so subtracting 10 modulo 16 on the low nibble is exact
  assign w_sum_dig = w_sum_c ? (w_sum[3:0] - 4'd10) : w_sum[3:0];

  assign w_dif_b   = ({1'b0, w_xd} < ({1'b0, w_yd} + {4'b0000, r_c}));
  assign w_dif     = {1'b0, w_xd} + (w_dif_b ? 5'd10 : 5'd0) - {1'b0, w_yd} - {4'b0000, r_c};
  assign w_dif_dig = w_dif[3:0];

  always_comb begin
    w_state_nxt    = r_state;
    w_a_nxt        = r_a;
    w_b_nxt        = r_b;
    w_x_nxt        = r_x;
    w_y_nxt        = r_y;
    w_r_nxt        = r_r;
    w_c_nxt        = r_c;
    w_idx_nxt      = r_idx;
    w_op_nxt       = r_op;
    w_setup_nxt    = r_setup;
    w_neg_pend_nxt = r_neg_pend;
    w_neg_nxt      = r_neg;

    if (bus.in_clr) begin
      w_state_nxt = StEnterA;
      w_a_nxt     = '0;
      w_b_nxt     = '0;
      w_r_nxt     = '0;
      w_neg_nxt   = 1'b0;
      w_setup_nxt = 1'b0;
    end else begin
      unique case (r_state)
        StEnterA: begin
          if (bus.in_add || bus.in_sub) begin
            w_state_nxt = StEnterB;
            w_b_nxt     = '0;
          end else if (w_key_ok) begin
            w_a_nxt      = r_a << 4;
            w_a_nxt[3:0] = bus.key;
          end
        end
        StEnterB: begin
          if (bus.in_add || bus.in_sub) begin
            w_state_nxt = StCalc;
            w_op_nxt    = ~bus.in_add;
            w_idx_nxt   = '0;
            w_c_nxt     = 1'b0;
            w_r_nxt     = '0;
            w_setup_nxt = 1'b1;
          end else if (w_key_ok) begin
            w_b_nxt      = r_b << 4;
            w_b_nxt[3:0] = bus.key;
          end
        end
        StCalc: begin
          if (r_setup) begin
            w_setup_nxt = 1'b0;
            if (r_op && (r_a < r_b)) begin
              w_x_nxt        = r_b;
              w_y_nxt        = r_a;
              w_neg_pend_nxt = 1'b1;
            end else begin
              w_x_nxt        = r_a;
              w_y_nxt        = r_b;
              w_neg_pend_nxt = 1'b0;
            end
          end else begin
            w_r_nxt[w_lsb +: 4] = r_op ? w_dif_dig : w_sum_dig;
            w_c_nxt             = r_op ? w_dif_b : w_sum_c;
            w_idx_nxt           = r_idx + IW'(1);
            if (r_idx == IW'(N - 1)) begin
              w_r_nxt[DW +: 4] = {3'b000, r_op ? 1'b0 : w_sum_c};
              w_neg_nxt        = r_neg_pend;
              w_idx_nxt        = '0;
              w_state_nxt      = StResult;
            end
          end
        end
        StResult: begin
          if (bus.in_add || bus.in_sub || w_key_ok) begin
            w_state_nxt = StEnterA;
            w_a_nxt     = '0;
            w_b_nxt     = '0;
            w_r_nxt     = '0;
            w_neg_nxt   = 1'b0;
            // a digit key starts the next calculation immediately
            if (!(bus.in_add || bus.in_sub)) w_a_nxt[3:0] = bus.key;
          end
        end
        default: w_state_nxt = StEnterA;
      endcase
    end

    // Display reflects the state being entered so outputs stay registered
    w_disp_nxt = '0;
    unique case (w_state_nxt)
      StEnterA:        w_disp_nxt[2*DW-1 -: DW] = w_a_nxt;
      StEnterB, StCalc: w_disp_nxt = {w_a_nxt, w_b_nxt};
      StResult:        w_disp_nxt[DW+3:0] = w_r_nxt;
      default:         w_disp_nxt = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StEnterA;
      r_a        <= '0;
      r_b        <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_r        <= '0;
      r_c        <= 1'b0;
      r_idx      <= '0;
      r_op       <= 1'b0;
      r_setup    <= 1'b0;
      r_neg_pend <= 1'b0;
      r_neg      <= 1'b0;
      r_disp     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_mode     <= 2'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_a        <= w_a_nxt;
      r_b        <= w_b_nxt;
      r_x        <= w_x_nxt;
      r_y        <= w_y_nxt;
      r_r        <= w_r_nxt;
      r_c        <= w_c_nxt;
      r_idx      <= w_idx_nxt;
      r_op       <= w_op_nxt;
      r_setup    <= w_setup_nxt;
      r_neg_pend <= w_neg_pend_nxt;
      r_neg      <= w_neg_nxt;
      r_disp     <= w_disp_nxt;
      r_busy     <= (w_state_nxt == StCalc);
      r_done     <= (w_state_nxt == StResult) && (r_state != StResult);
      r_mode     <= w_state_nxt;
    end
  end

  assign bus.disp = r_disp;
  assign bus.neg  = r_neg;
  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.mode = r_mode;
endmodule
